// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 stream capture path.
// FSM encoding and sensor default geometry.
package ov7670_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_ACTIVE  = 2'd2
   } cap_state_t;

   localparam int QVGA_W = 320;
   localparam int QVGA_H = 240;

   // first byte on the bus is the most significant pixel byte
   localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO for captured pixels.
// Full-plus-pop writes are accepted; read data is zero when empty.
module capture_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign rdata = empty ? '0 : mem[rd_q[AW-1:0]];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_q[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + (AW+1)'(1);
         if (rd_en) rd_q <= rd_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/ov7670_stream_capture.sv
// OV7670 bus capture: sync, pixel assembly, crop window, FIFO,
// and valid/ready pixel stream with frame/line sideband.
module ov7670_stream_capture
   import ov7670_pkg::*;
#(
   parameter int BYTES_PER_PIXEL = 2,
   parameter int FIFO_DEPTH      = 16,
   parameter int X_START         = 0,
   parameter int X_END           = QVGA_W - 1,
   parameter int Y_START         = 0,
   parameter int Y_END           = QVGA_H - 1,
   parameter int CNT_W           = 10
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         cam_pclk,
   input  logic                         cam_vsync,
   input  logic                         cam_href,
   input  logic [7:0]                   cam_data,
   input  logic                         capture_en,
   input  logic                         clear_ovf,
   output logic [8*BYTES_PER_PIXEL-1:0] pixel_data,
   output logic                         pixel_valid,
   input  logic                         pixel_ready,
   output logic                         pixel_sof,
   output logic                         pixel_eol,
   output logic                         frame_active,
   output logic [15:0]                  frame_count,
   output logic                         overflow
);

   localparam int PW = 8 * BYTES_PER_PIXEL;
   localparam int EW = PW + 2;
   localparam logic [1:0] LAST_PH = 2'(BYTES_PER_PIXEL - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [10:0]      sync1;
   logic [10:0]      sync2;
   logic             pclk_rise_q;
   logic             href_fall_q;
   logic             vs_rise_q;
   logic             vs_fall_q;
   cap_state_t       state_q;
   cap_state_t       state_d;
   logic [1:0]       phase_q;
   logic [CNT_W-1:0] col_q;
   logic [CNT_W-1:0] line_q;
   logic [PW-1:0]    pix_q;
   logic [PW+7:0]    pix_cat;
   logic [PW-1:0]    pix_nxt;
   logic             push_q;
   logic [EW-1:0]    entry_q;
   logic             pushed_q;
   logic             take;
   logic             in_win;
   logic             at_sof;
   logic             at_eol;
   logic             pop;
   logic             drop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [EW-1:0]    fifo_rdata;

   // bit map: 10 pclk, 9 vsync, 8 href, 7:0 data
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1       <= '0;
         sync2       <= '0;
         pclk_rise_q <= 1'b0;
         href_fall_q <= 1'b0;
         vs_rise_q   <= 1'b0;
         vs_fall_q   <= 1'b0;
      end else begin
         sync1       <= {cam_pclk, cam_vsync, cam_href, cam_data};
         sync2       <= sync1;
         pclk_rise_q <= sync1[10] & ~sync2[10];
         href_fall_q <= ~sync1[8] & sync2[8];
         vs_rise_q   <= sync1[9] & ~sync2[9];
         vs_fall_q   <= ~sync1[9] & sync2[9];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (capture_en) state_d = ST_WAIT_VS;
         ST_WAIT_VS:
            if (vs_fall_q)
               state_d = capture_en ? ST_ACTIVE : ST_IDLE;
         ST_ACTIVE:
            if (vs_rise_q) state_d = ST_WAIT_VS;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      frame_active = (state_q == ST_ACTIVE);
   end

   assign take    = frame_active & pclk_rise_q & sync2[8];
   assign pix_cat = {pix_q, sync2[7:0]};
   assign pix_nxt = pix_cat[PW-1:0];

   assign in_win = (int'(col_q) >= X_START) &&
                   (int'(col_q) <= X_END) &&
                   (int'(line_q) >= Y_START) &&
                   (int'(line_q) <= Y_END);
   assign at_sof = (int'(col_q) == X_START) &&
                   (int'(line_q) == Y_START);
   assign at_eol = (int'(col_q) == X_END);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         phase_q <= '0;
         col_q   <= '0;
         line_q  <= '0;
         pix_q   <= '0;
         push_q  <= 1'b0;
         entry_q <= '0;
      end else begin
         push_q <= 1'b0;
         if (vs_fall_q) begin
            phase_q <= '0;
            col_q   <= '0;
            line_q  <= '0;
         end else if (vs_rise_q) begin
            phase_q <= '0;
         end else if (href_fall_q && frame_active) begin
            phase_q <= '0;
            col_q   <= '0;
            if (line_q != CNT_MAX)
               line_q <= line_q + CNT_W'(1);
         end else if (take) begin
            pix_q <= pix_nxt;
            if (phase_q == LAST_PH) begin
               phase_q <= '0;
               if (col_q != CNT_MAX)
                  col_q <= col_q + CNT_W'(1);
               push_q  <= in_win;
               entry_q <= {at_sof, at_eol, pix_nxt};
            end else begin
               phase_q <= phase_q + 2'd1;
            end
         end
      end
   end

   assign pop  = pixel_valid & pixel_ready;
   assign drop = push_q & fifo_full & ~pop;

   // a frame only counts once it has produced a pixel
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pushed_q    <= 1'b0;
         frame_count <= '0;
         overflow    <= 1'b0;
      end else begin
         if (vs_fall_q)   pushed_q <= 1'b0;
         else if (push_q) pushed_q <= 1'b1;
         if (frame_active && vs_rise_q && (pushed_q || push_q))
            frame_count <= frame_count + 16'd1;
         overflow <= drop | (overflow & ~clear_ovf);
      end
   end

   capture_fifo #(
      .WIDTH(EW),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock(clock),
      .reset(reset),
      .push (push_q),
      .wdata(entry_q),
      .pop  (pop),
      .rdata(fifo_rdata),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   assign pixel_valid = ~fifo_empty;
   assign {pixel_sof, pixel_eol, pixel_data} = fifo_rdata;

endmodule

// File: tb/tb_ov7670_stream_capture.sv
// Directed bench: 8x4 frames through a 2..5 x 1..2 window,
// drained and compared against a bench-side expectation queue.
`timescale 1ns/1ps
module tb_ov7670_stream_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cam_pclk = 1'b0;
   logic        cam_vsync = 1'b1;
   logic        cam_href = 1'b0;
   logic [7:0]  cam_data = '0;
   logic        capture_en = 1'b0;
   logic        clear_ovf = 1'b0;
   logic [15:0] pixel_data;
   logic        pixel_valid;
   logic        pixel_ready = 1'b0;
   logic        pixel_sof;
   logic        pixel_eol;
   logic        frame_active;
   logic [15:0] frame_count;
   logic        overflow;

   int          n_tests = 0;
   int          n_fail = 0;
   bit          meas_lat = 1'b0;
   bit          exp_ovf = 1'b0;
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   ov7670_stream_capture #(
      .BYTES_PER_PIXEL(2),
      .FIFO_DEPTH     (16),
      .X_START        (2),
      .X_END          (5),
      .Y_START        (1),
      .Y_END          (2),
      .CNT_W          (10)
   ) dut (
      .clock       (clk),
      .reset       (rst_n),
      .cam_pclk    (cam_pclk),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_data    (cam_data),
      .capture_en  (capture_en),
      .clear_ovf   (clear_ovf),
      .pixel_data  (pixel_data),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .pixel_sof   (pixel_sof),
      .pixel_eol   (pixel_eol),
      .frame_active(frame_active),
      .frame_count (frame_count),
      .overflow    (overflow)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pix_val(int c, int l);
      logic [7:0] h;
      if (c == 2 && l == 1) return 16'hA53C;
      h = 8'(l * 16 + c);
      return {h, ~h};
   endfunction

   // called on a negedge; pclk low 2 clocks, high 2 clocks
   task automatic send_byte(input logic [7:0] b, input bit lat);
      cam_pclk = 1'b0;
      cam_data = b;
      repeat (2) @(negedge clk);
      cam_pclk = 1'b1;
      if (lat) begin
         fork
            begin
               repeat (3) @(negedge clk);
               check("lat_p2_low", pixel_valid, 0);
               @(negedge clk);
               check("lat_p3_high", pixel_valid, 1);
            end
         join_none
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(input int ncols, input int nlines,
                             input int short_line,
                             input int short_cols,
                             input int en_off_line,
                             input int abort_pix,
                             input bit exp_act);
      int npix = 0;
      int nc;
      logic [15:0] pv;
      bit win;
      @(negedge clk);
      cam_vsync = 1'b0;
      repeat (6) @(negedge clk);
      for (int l = 0; l < nlines; l++) begin
         if (l == en_off_line) capture_en = 1'b0;
         if (l == 1) check("frame_active", frame_active, exp_act);
         cam_href = 1'b1;
         cam_pclk = 1'b0;
         nc = (l == short_line) ? short_cols : ncols;
         for (int c = 0; c < nc; c++) begin
            pv = pix_val(c, l);
            send_byte(pv[15:8], 1'b0);
            send_byte(pv[7:0], meas_lat && c == 2 && l == 1);
            win = (c >= 2 && c <= 5 && l >= 1 && l <= 2);
            if (exp_act && win) begin
               if (exp_q.size() < 16)
                  exp_q.push_back({c == 2 && l == 1, c == 5, pv});
               else
                  exp_ovf = 1'b1;
               npix++;
               if (npix == abort_pix) return;
            end
         end
         if (l == short_line) send_byte(8'hEE, 1'b0);
         cam_pclk = 1'b0;
         cam_href = 1'b0;
         repeat (6) @(negedge clk);
      end
      cam_vsync = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic drain();
      @(negedge clk);
      pixel_ready = 1'b1;
      while (exp_q.size() > 0) begin
         check("pixel", {pixel_valid, pixel_sof, pixel_eol,
                         pixel_data}, {1'b1, exp_q.pop_front()});
         @(negedge clk);
      end
      pixel_ready = 1'b0;
      check("drained_valid", pixel_valid, 0);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: no finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid", pixel_valid, 0);
      check("rst_data", pixel_data, 0);
      check("rst_active", frame_active, 0);
      check("rst_count", frame_count, 0);
      check("rst_ovf", overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);
      capture_en = 1'b1;
      repeat (4) @(negedge clk);
      check("wait_vs_inactive", frame_active, 0);

      // window frame with latency probe on pixel (2,1)
      meas_lat = 1'b1;
      send_frame(8, 4, -1, 0, -1, 0, 1'b1);
      meas_lat = 1'b0;
      check("count_after_f1", frame_count, 1);
      check("active_after_f1", frame_active, 0);
      check("ovf_after_f1", overflow, 0);
      drain();

      // three frames with ready low: 24 pixels into 16 slots
      exp_ovf = 1'b0;
      for (int f = 0; f < 3; f++)
         send_frame(8, 4, -1, 0, -1, 0, 1'b1);
      check("ovf_full_valid", pixel_valid, 1);
      check("ovf_set", overflow, exp_ovf);
      check("count_after_ovf", frame_count, 4);
      @(negedge clk);
      clear_ovf = 1'b1;
      @(negedge clk);
      clear_ovf = 1'b0;
      check("ovf_cleared", overflow, 0);
      drain();

      // line 1 ends after a half pixel at col 5
      send_frame(8, 4, 1, 5, -1, 0, 1'b1);
      check("count_short", frame_count, 5);
      drain();

      // enable drops mid-frame: this frame completes, next ignored
      send_frame(8, 4, -1, 0, 1, 0, 1'b1);
      check("count_en_off", frame_count, 6);
      drain();
      send_frame(8, 4, -1, 0, -1, 0, 1'b0);
      check("count_no_f2", frame_count, 6);
      check("no_f2_valid", pixel_valid, 0);

      // reset mid-line with five pixels queued
      capture_en = 1'b1;
      repeat (4) @(negedge clk);
      send_frame(8, 4, -1, 0, -1, 5, 1'b1);
      repeat (4) @(negedge clk);
      check("pre_rst_valid", pixel_valid, 1);
      check("pre_rst_active", frame_active, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", pixel_valid, 0);
      check("mid_rst_data", pixel_data, 0);
      check("mid_rst_sof", pixel_sof, 0);
      check("mid_rst_eol", pixel_eol, 0);
      check("mid_rst_active", frame_active, 0);
      check("mid_rst_count", frame_count, 0);
      check("mid_rst_ovf", overflow, 0);
      @(negedge clk);
      check("mid_rst_valid_next", pixel_valid, 0);
      exp_q.delete();
      cam_href = 1'b0;
      cam_pclk = 1'b0;
      cam_vsync = 1'b1;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
